fpu_exec_unit: RTL and testbench
================================

Name: fpu_exec_unit

Overview:
- Execution-side responder for the FPU control path. The control unit issues FPUControl plus operands; this block accepts them over a valid/ready handshake and executes IEEE-754 single-precision add, sub, mul or div over several cycles.
- It returns the result, the destination tag and exception flags over a second valid/ready handshake.
- It sits between the control unit / register file read stage and the ALU/FPU result mux.

Parameters:
- MUL_CYCLES, 24, shift-add iterations for mantissa multiply; fixed at 24 for single precision.
- DIV_CYCLES, 25, restoring-division quotient bits generated.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous active-low reset
- req_valid  input  1  issue request from control unit
- req_ready  output  1  unit can accept a request; high only in IDLE
- fpu_op  input  3  FPUControl: 000 add, 001 sub, 010 mul, 011 div, 1xx reserved
- op_a  input  32  operand A, IEEE single
- op_b  input  32  operand B, IEEE single
- rd_in  input  5  destination register tag
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- result  output  32  IEEE single result
- rd_out  output  5  tag captured at accept
- flags  output  4  {NV invalid, DZ div-by-zero, OF overflow, UF underflow}

Behaviour:
- Clock and reset: one clock (CLK); RST is asynchronous and active-low. While RST=0: state=IDLE, req_ready=1, resp_valid=0, result=0, rd_out=0, flags=0, all datapath registers cleared. Reset mid-operation aborts the operation with no response.
- Accept: occurs on the edge where req_valid and req_ready are both 1. fpu_op, op_a, op_b and rd_in are captured; req_ready drops the following cycle.
- FSM states: IDLE -> UNPACK -> EXEC -> NORM -> PACK -> DONE -> IDLE.
  - UNPACK (1 cycle): split sign/exponent/mantissa. Hidden bit is 1 if exp!=0; exp==0 operands are flushed to zero.
  - UNPACK special-case detection routes straight to PACK. Special cases:
    - any exp==255 operand -> 0x7FC00000, NV
    - div with B==0 and A!=0 -> signed inf 0x7F800000|sign, DZ
    - div 0/0 -> 0x7FC00000, NV
    - reserved op -> 0x00000000, NV
  - EXEC, add/sub: 1 cycle. Sub inverts B's sign. Align the smaller exponent with a right shift; shifts of 26 or more zero the mantissa, and shifted-out bits are discarded. Then add or subtract the 25-bit magnitudes.
  - EXEC, mul: MUL_CYCLES cycles of shift-add producing a 48-bit product. Exponent = ea+eb-127.
  - EXEC, div: DIV_CYCLES cycles of restoring division producing 25 quotient bits. Exponent = ea-eb+127.
  - NORM (1 cycle): combinational leading-zero count, then left/right shift to 1.xxx and exponent adjust.
  - NORM rounding and range: rounding is truncation (round toward zero). Exponent >=255 -> signed inf, OF. Exponent <=0 -> signed zero, UF.
  - PACK (1 cycle): registers result, rd_out and flags.
  - DONE: resp_valid=1. Outputs are held stable until resp_ready=1; on that edge resp_valid->0 and state->IDLE. No new request is accepted in the same cycle.
- Zero results: exact cancellation in add/sub -> +0. Mul/div zero results -> sign = sa^sb.
- Latency from accept edge to the edge that raises resp_valid:
  - add/sub: 4
  - mul: 3+MUL_CYCLES = 27
  - div: 3+DIV_CYCLES = 28
  - special/reserved: 2
- Throughput: one operation in flight; no pipelining.
- flags hold 0 unless a condition fires; they are cleared at each accept.
- Inputs are ignored while not in IDLE.

Test Plan:
- add 0x3F800000 + 0x40000000, rd_in=5 -> result 0x40400000, flags 0, rd_out 5, resp_valid rises 4 edges after accept; sub 0x40400000 - 0x3F800000 -> 0x40000000.
- mul 0x3FC00000 * 0x40000000 -> 0x40400000 after 27 edges; mul 0x7F000000 * 0x40000000 -> 0x7F800000, OF.
- div 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated) after 28 edges; div 0x3F800000 / 0x00000000 -> 0x7F800000, DZ, after 2 edges.
- op_a 0x7F800000 add anything -> 0x7FC00000, NV; fpu_op=3'b101 -> 0x00000000, NV, 2 edges.
- backpressure: hold resp_ready=0 for 10 cycles after a mul -> result/rd_out/flags stable, req_ready=0 throughout, req_valid pulses ignored; raise resp_ready -> IDLE next cycle, req_ready=1.
- reset mid-div (cycle 10 of EXEC) -> resp_valid=0, req_ready=1 immediately; a subsequent add 0x3F800000+0x3F800000 -> 0x40000000 with correct latency.

Source files
------------

// File: rtl/fpu_exec_unit.sv
// fpu_exec_unit: multi-cycle IEEE-754 single-precision add/sub/mul/div responder.
// Takes one request at a time over req_valid/req_ready and returns the result
// over resp_valid/resp_ready. Rounding is truncation, and denormals are flushed to zero.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// UNPACK | decode operands, detect special cases, seed the datapath
// EXEC   | add/sub (1 cycle), shift-add multiply, or restoring divide
// NORM   | leading-zero normalize, range check, build the pending result
// PACK   | register result, rd_out and flags
// DONE   | resp_valid high, hold until resp_ready
module fpu_exec_unit #(
  parameter int MUL_CYCLES = 24,
  parameter int DIV_CYCLES = 25
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  fpu_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, PACK, DONE} state_t;

  state_t             state;
  logic [2:0]         op_r;
  logic [31:0]        a_r, b_r;
  logic [4:0]         rd_r;
  logic               res_sign;
  logic signed [10:0] er;
  logic [47:0]        nm;
  logic [47:0]        mcand;
  logic [23:0]        mplier;
  logic [25:0]        rem;
  logic [4:0]         cnt;
  logic [31:0]        pend_res;
  logic [3:0]         pend_flags;

  logic        sa, sb, sb_add, a_zero, b_zero, a_inf, b_inf;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  // Operand field decode from the captured request; exp==0 flushes to zero.
  always_comb begin
    sa     = a_r[31];
    sb     = b_r[31];
    ea     = a_r[30:23];
    eb     = b_r[30:23];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF);
    b_inf  = (eb == 8'hFF);
    ma     = a_zero ? 24'd0 : {1'b1, a_r[22:0]};
    mb     = b_zero ? 24'd0 : {1'b1, b_r[22:0]};
    sb_add = sb ^ (op_r == 3'b001);
  end

  logic [7:0]  add_e, add_d;
  logic [23:0] big_m, small_m;
  logic        big_s, small_s;
  logic [24:0] mag_x, mag_y, add_sum;
  logic        add_sign;

  // Add/sub: align the smaller exponent, then add or subtract magnitudes.
  always_comb begin
    if (ea >= eb) begin
      add_e = ea; add_d = ea - eb;
      big_m = ma; big_s = sa; small_m = mb; small_s = sb_add;
    end else begin
      add_e = eb; add_d = eb - ea;
      big_m = mb; big_s = sb_add; small_m = ma; small_s = sa;
    end
    mag_x = {1'b0, big_m};
    mag_y = (add_d >= 8'd26) ? 25'd0 : ({1'b0, small_m} >> add_d);
    if (big_s == small_s) begin
      add_sum = mag_x + mag_y; add_sign = big_s;
    end else if (mag_x >= mag_y) begin
      add_sum = mag_x - mag_y; add_sign = big_s;
    end else begin
      add_sum = mag_y - mag_x; add_sign = small_s;
    end
    if (add_sum == 25'd0) add_sign = 1'b0;
  end

  logic [5:0]         lz;
  logic [47:0]        norm_shift;
  logic signed [10:0] norm_exp;
  logic [22:0]        norm_mant;

  // Leading-zero count and normalize; bit 47 of nm carries exponent er.
  always_comb begin
    lz = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (nm[i]) lz = 6'(47 - i);
    end
    norm_shift = nm << lz;
    norm_exp   = er - $signed({5'd0, lz});
    norm_mant  = 23'(norm_shift >> 24);
  end

  logic        div_ge;
  logic [25:0] rem_sub;

  // One restoring-division step.
  always_comb begin
    rem_sub = rem - {2'b00, mb};
    div_ge  = (rem >= {2'b00, mb});
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE; req_ready <= 1'b1; resp_valid <= 1'b0;
      result <= '0; rd_out <= '0; flags <= '0;
      op_r <= '0; a_r <= '0; b_r <= '0; rd_r <= '0;
      res_sign <= 1'b0; er <= '0; nm <= '0; mcand <= '0; mplier <= '0;
      rem <= '0; cnt <= '0; pend_res <= '0; pend_flags <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_r <= fpu_op; a_r <= op_a; b_r <= op_b; rd_r <= rd_in;
          flags <= 4'd0; pend_flags <= 4'd0; req_ready <= 1'b0;
          state <= UNPACK;
        end
        UNPACK: begin
          res_sign <= sa ^ sb;
          nm <= '0; mcand <= {24'd0, ma}; mplier <= mb; rem <= {2'b00, ma};
          if (op_r == 3'b010) begin
            cnt <= 5'(MUL_CYCLES - 1);
            er  <= $signed({3'b0, ea}) + $signed({3'b0, eb}) - 11'sd126;
          end else begin
            cnt <= 5'(DIV_CYCLES - 1);
            er  <= $signed({3'b0, ea}) - $signed({3'b0, eb}) + 11'sd150;
          end
          state <= PACK;
          if (op_r[2]) begin
            pend_res <= 32'h0000_0000; pend_flags <= 4'b1000;
          end else if (a_inf || b_inf) begin
            pend_res <= 32'h7FC0_0000; pend_flags <= 4'b1000;
          end else if (op_r == 3'b011 && b_zero) begin
            if (a_zero) begin
              pend_res <= 32'h7FC0_0000; pend_flags <= 4'b1000;
            end else begin
              pend_res <= {sa ^ sb, 8'hFF, 23'd0}; pend_flags <= 4'b0100;
            end
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op_r[1:0])
            2'b10: begin
              if (mplier[0]) nm <= nm + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            2'b11: begin
              nm  <= {nm[46:0], div_ge};
              rem <= {25'(div_ge ? rem_sub : rem), 1'b0};
            end
            default: begin
              nm <= {23'd0, add_sum};
              er <= $signed({3'b0, add_e}) + 11'sd24;
              res_sign <= add_sign;
            end
          endcase
          if (!op_r[1] || cnt == 5'd0) state <= NORM;
          else cnt <= cnt - 5'd1;
        end
        NORM: begin
          if (nm == 48'd0) begin
            pend_res <= {res_sign, 31'd0};
          end else if (norm_exp >= 11'sd255) begin
            pend_res <= {res_sign, 8'hFF, 23'd0}; pend_flags <= 4'b0010;
          end else if (norm_exp <= 11'sd0) begin
            pend_res <= {res_sign, 31'd0}; pend_flags <= 4'b0001;
          end else begin
            pend_res <= {res_sign, norm_exp[7:0], norm_mant};
          end
          state <= PACK;
        end
        PACK: begin
          result <= pend_res; rd_out <= rd_r; flags <= pend_flags;
          resp_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0; req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_exec_unit.sv
// Directed-vector bench for fpu_exec_unit with hand-computed expected results.
module tb_fpu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  fpu_op = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [3:0]  flags;

  int n_vec  = 0;
  int n_miss = 0;

  fpu_exec_unit #(.MUL_CYCLES(24), .DIV_CYCLES(25)) dut (
    .CLK(clk), .RST(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .fpu_op(fpu_op), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .rd_out(rd_out), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for resp_valid with resp_ready held low.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; fpu_op = op; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_in = 5'd31; fpu_op = 3'b111;
    lat = 0;
    while (!resp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rd_out"}, 32'(rd_out), 32'(rd));
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
  endtask

  task automatic release_resp(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_resp_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_1_2", 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000, 4'b0000, 4);
    release_resp("add_1_2");
    run_op("sub_3_1", 3'b001, 32'h4040_0000, 32'h3F80_0000, 5'd7, 32'h4000_0000, 4'b0000, 4);
    release_resp("sub_3_1");
    run_op("sub_cancel", 3'b001, 32'h3F80_0000, 32'h3F80_0000, 5'd2, 32'h0000_0000, 4'b0000, 4);
    release_resp("sub_cancel");
    run_op("mul_1p5_2", 3'b010, 32'h3FC0_0000, 32'h4000_0000, 5'd9, 32'h4040_0000, 4'b0000, 27);
    release_resp("mul_1p5_2");
    run_op("mul_of", 3'b010, 32'h7F00_0000, 32'h4000_0000, 5'd3, 32'h7F80_0000, 4'b0010, 27);
    release_resp("mul_of");
    run_op("mul_zero", 3'b010, 32'h0000_0000, 32'hC000_0000, 5'd4, 32'h8000_0000, 4'b0000, 27);
    release_resp("mul_zero");
    run_op("mul_uf", 3'b010, 32'h0080_0000, 32'h0080_0000, 5'd6, 32'h0000_0000, 4'b0001, 27);
    release_resp("mul_uf");
    run_op("div_1_3", 3'b011, 32'h3F80_0000, 32'h4040_0000, 5'd11, 32'h3EAA_AAAA, 4'b0000, 28);
    release_resp("div_1_3");
    run_op("div_by_zero", 3'b011, 32'h3F80_0000, 32'h0000_0000, 5'd12, 32'h7F80_0000, 4'b0100, 2);
    release_resp("div_by_zero");
    run_op("div_0_0", 3'b011, 32'h0000_0000, 32'h0000_0000, 5'd13, 32'h7FC0_0000, 4'b1000, 2);
    release_resp("div_0_0");
    run_op("add_inf", 3'b000, 32'h7F80_0000, 32'h3F80_0000, 5'd14, 32'h7FC0_0000, 4'b1000, 2);
    release_resp("add_inf");
    run_op("reserved", 3'b101, 32'h3F80_0000, 32'h3F80_0000, 5'd15, 32'h0000_0000, 4'b1000, 2);
    release_resp("reserved");

    // Backpressure: response must hold while junk requests are offered.
    run_op("bp_mul", 3'b010, 32'h3FC0_0000, 32'h4000_0000, 5'd21, 32'h4040_0000, 4'b0000, 27);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b1; fpu_op = 3'b000; op_a = $urandom; op_b = $urandom; rd_in = 5'd1;
      check("bp_result", result, 32'h4040_0000);
      check("bp_rd_out", 32'(rd_out), 32'd21);
      check("bp_flags", 32'(flags), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
    end
    req_valid = 1'b0;
    release_resp("bp");

    // Reset in the middle of a divide aborts it with no response.
    @(negedge clk);
    req_valid = 1'b1; fpu_op = 3'b011; op_a = 32'h3F80_0000; op_b = 32'h4040_0000; rd_in = 5'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd10, 32'h4000_0000, 4'b0000, 4);
    release_resp("post_rst_add");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
